// File: rtl/instr_fetch.sv
// IF stage: reads the word-addressed instruction ROM at the PC and registers it into IF/ID.
// Optional FETCH_PERF_EN adds fetchCount/stallCount performance counters.
module instr_fetch #(
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned ADDR_BITS = 8,
   parameter logic [31:0] NOP_WORD  = 32'h00000000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [31:0]          address,
   input  logic                 resetControl,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 romWe,
   input  logic [ADDR_BITS-1:0] romWaddr,
   input  logic [31:0]          romWdata,
   output logic [31:0]          instruction,
   output logic [31:0]          pcOut,
   output logic [31:0]          pcPlus4,
   output logic                 valid,
   output logic                 fetchFault
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]          fetchCount,
   output logic [31:0]          stallCount
`endif
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {WAIT, FETCH, HOLD} state_t;

   state_t state, state_nxt;

   logic [XLEN-1:0] rom [DEPTH];
   logic [XLEN-1:0] rom_rdata;
   logic            bad_addr;

   logic [XLEN-1:0] ins_nxt, pc_nxt, pc4_nxt;
   logic            valid_nxt, fault_nxt, load_valid;

   // Loader writes are only honoured while the stage is idle.
   always_ff @(posedge clock) begin
      if (!reset && romWe && state == WAIT) begin
         rom[romWaddr] <= romWdata;
      end
   end

   assign rom_rdata = rom[address[ADDR_BITS+1:2]];
   assign bad_addr  = (address[1:0] != 2'b00) || ((address >> (ADDR_BITS + 2)) != '0);

   // State and IF/ID register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= WAIT;
         instruction <= NOP_WORD;
         pcOut       <= '0;
         pcPlus4     <= '0;
         valid       <= 1'b0;
         fetchFault  <= 1'b0;
      end else begin
         state       <= state_nxt;
         instruction <= ins_nxt;
         pcOut       <= pc_nxt;
         pcPlus4     <= pc4_nxt;
         valid       <= valid_nxt;
         fetchFault  <= fault_nxt;
      end
   end

   // Next-state: resetControl > flush > stall > fetch.
   always_comb begin
      state_nxt = state;
      case (state)
         WAIT:    state_nxt = resetControl ? WAIT : FETCH;
         default: begin
            if (resetControl)  state_nxt = WAIT;
            else if (flush)    state_nxt = FETCH;
            else if (stall)    state_nxt = HOLD;
            else               state_nxt = FETCH;
         end
      endcase
   end

   // Next IF/ID contents.
   always_comb begin
      ins_nxt    = instruction;
      pc_nxt     = pcOut;
      pc4_nxt    = pcPlus4;
      valid_nxt  = valid;
      fault_nxt  = fetchFault;
      load_valid = 1'b0;
      if (state == WAIT || resetControl) begin
         ins_nxt   = NOP_WORD;
         pc_nxt    = '0;
         pc4_nxt   = '0;
         valid_nxt = 1'b0;
         fault_nxt = 1'b0;
      end else if (flush) begin
         ins_nxt   = NOP_WORD;
         pc_nxt    = address;
         pc4_nxt   = address + XLEN'(4);
         valid_nxt = 1'b0;
         fault_nxt = 1'b0;
      end else if (!stall) begin
         ins_nxt    = bad_addr ? NOP_WORD : rom_rdata;
         pc_nxt     = address;
         pc4_nxt    = address + XLEN'(4);
         valid_nxt  = !bad_addr;
         fault_nxt  = bad_addr;
         load_valid = !bad_addr;
      end
   end

`ifdef FETCH_PERF_EN
   // Counters wrap naturally at 2^32.
   always_ff @(posedge clock) begin
      if (reset) begin
         fetchCount <= '0;
         stallCount <= '0;
      end else begin
         if (load_valid)         fetchCount <= fetchCount + XLEN'(1);
         if (state_nxt == HOLD)  stallCount <= stallCount + XLEN'(1);
      end
   end
`else
   logic unused_load_valid;
   assign unused_load_valid = load_valid;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: a reference model pushes expected IF/ID contents per
// edge; they are popped and compared one cycle later.
module tb_instr_fetch;

   localparam int unsigned DEPTH     = 256;
   localparam int unsigned ADDR_BITS = 8;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        v;
      logic        f;
      logic [31:0] fc;
      logic [31:0] sc;
   } exp_t;

   logic                 clock = 1'b0;
   logic                 reset, resetControl, stall, flush, romWe;
   logic [31:0]          address, romWdata;
   logic [ADDR_BITS-1:0] romWaddr;
   logic [31:0]          instruction, pcOut, pcPlus4;
   logic                 valid, fetchFault;
`ifdef FETCH_PERF_EN
   logic [31:0]          fetchCount, stallCount;
`endif

   int   errors = 0;
   int   checks = 0;
   exp_t sbq[$];

   // Reference model state: 0=WAIT 1=FETCH 2=HOLD
   int          m_st = 0;
   exp_t        m_out = '0;
   logic [31:0] m_rom [DEPTH];

   always #5 clock = ~clock;

   instr_fetch #(.DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS), .NOP_WORD(32'h00000000)) dut (
      .clock(clock), .reset(reset), .address(address), .resetControl(resetControl),
      .stall(stall), .flush(flush), .romWe(romWe), .romWaddr(romWaddr), .romWdata(romWdata),
      .instruction(instruction), .pcOut(pcOut), .pcPlus4(pcPlus4), .valid(valid),
      .fetchFault(fetchFault)
`ifdef FETCH_PERF_EN
      , .fetchCount(fetchCount), .stallCount(stallCount)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, model the edge, push expectation, then compare after the edge.
   task automatic cyc(input string nm, input logic r, input logic rc, input logic st,
                      input logic fl, input logic [31:0] a, input logic we,
                      input logic [7:0] wa, input logic [31:0] wd);
      exp_t e;
      logic bad;
      @(negedge clock);
      reset = r; resetControl = rc; stall = st; flush = fl; address = a;
      romWe = we; romWaddr = wa; romWdata = wd;
      bad = (a[1:0] != 2'b00) || (a >= 32'h400);
      if (!r && we && m_st == 0) m_rom[wa] = wd;
      if (r) begin
         m_st = 0; m_out = '0;
      end else if (m_st == 0) begin
         if (!rc) m_st = 1;
      end else if (rc) begin
         m_st = 0;
         m_out.ins = '0; m_out.pc = '0; m_out.pc4 = '0; m_out.v = 0; m_out.f = 0;
      end else if (fl) begin
         m_st = 1;
         m_out.ins = '0; m_out.pc = a; m_out.pc4 = a + 32'd4; m_out.v = 0; m_out.f = 0;
      end else if (st) begin
         m_st = 2;
         m_out.sc = m_out.sc + 1;
      end else begin
         m_st = 1;
         m_out.ins = bad ? 32'h0 : m_rom[a[9:2]];
         m_out.pc = a; m_out.pc4 = a + 32'd4; m_out.v = !bad; m_out.f = bad;
         if (!bad) m_out.fc = m_out.fc + 1;
      end
      sbq.push_back(m_out);
      @(posedge clock);
      #1;
      e = sbq.pop_front();
      check({nm, ".ins"}, instruction, e.ins);
      check({nm, ".pc"}, pcOut, e.pc);
      check({nm, ".pc4"}, pcPlus4, e.pc4);
      check({nm, ".valid"}, 32'(valid), 32'(e.v));
      check({nm, ".fault"}, 32'(fetchFault), 32'(e.f));
`ifdef FETCH_PERF_EN
      check({nm, ".fcnt"}, fetchCount, e.fc);
      check({nm, ".scnt"}, stallCount, e.sc);
`endif
   endtask

   task automatic go(input string nm, input logic st, input logic fl, input logic [31:0] a);
      cyc(nm, 1'b0, 1'b0, st, fl, a, 1'b0, 8'd0, 32'd0);
   endtask

   initial begin
      reset = 1; resetControl = 1; stall = 0; flush = 0; address = 0;
      romWe = 0; romWaddr = 0; romWdata = 0;
      cyc("rst", 1, 1, 0, 0, 32'h0, 0, 8'd0, 32'd0);
      // ROM load while waiting
      for (int i = 0; i < 16; i++) begin
         logic [31:0] d;
         d = (i == 0) ? 32'h20080005 : (i == 1) ? 32'h2009000A : 32'hA5000000 + 32'(i * 16'h0101);
         cyc("load", 0, 1, 0, 0, 32'h0, 1, 8'(i), d);
      end
      cyc("load255", 0, 1, 0, 0, 32'h0, 1, 8'd255, 32'hCAFEF00D);

      // 1: basic fetch, 1-cycle latency
      cyc("t1rst", 1, 1, 0, 0, 32'h0, 0, 8'd0, 32'd0);
      cyc("t1wait", 0, 1, 0, 0, 32'h0, 0, 8'd0, 32'd0);
      go("t1enter", 0, 0, 32'h0);
      go("t1a0", 0, 0, 32'h0);
      go("t1a4", 0, 0, 32'h4);
      // loader write while fetching is dropped
      cyc("weign", 0, 0, 0, 0, 32'h8, 1, 8'd2, 32'hDEADBEEF);

      // 2: stall three cycles while address moves
      go("t2s1", 1, 0, 32'hC);
      go("t2s2", 1, 0, 32'h10);
      go("t2s3", 1, 0, 32'h14);
      go("t2rel", 0, 0, 32'h18);

      // 3: flush beats stall, then normal fetch proves FETCH
      go("t3fl", 1, 1, 32'hC);
      go("t3nxt", 0, 0, 32'h10);
      go("t3hold", 1, 0, 32'h14);
      go("t3flh", 0, 1, 32'h1C);
      go("t3nxt2", 0, 0, 32'h8);

      // 4: misaligned and out-of-range faults, fetch keeps going
      go("t4mis", 0, 0, 32'h6);
      go("t4oor", 0, 0, 32'h400);
      go("t4top", 0, 0, 32'h3FC);
      go("t4ok", 0, 0, 32'h10);

      // resetControl mid-fetch clears and re-waits
      cyc("rcmid", 0, 1, 0, 0, 32'h4, 0, 8'd0, 32'd0);
      go("rcent", 0, 0, 32'h4);
      go("rcf", 0, 0, 32'h4);

      // 5: reset mid-fetch, two waiting cycles, ROM preserved
      cyc("t5rst", 1, 0, 0, 0, 32'h14, 0, 8'd0, 32'd0);
      cyc("t5w1", 0, 1, 0, 0, 32'h4, 0, 8'd0, 32'd0);
      cyc("t5w2", 0, 1, 0, 0, 32'h4, 0, 8'd0, 32'd0);
      go("t5enter", 0, 0, 32'h4);
      go("t5f", 0, 0, 32'h4);
      go("t5f0", 0, 0, 32'h0);

      // 6: top-of-memory wrap of pcPlus4
      go("t6wrap", 0, 0, 32'hFFFFFFFC);
      go("t6after", 0, 0, 32'h3C);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
IF stage directly downstream of the program counter (pc). Consumes the PC `address`, reads the instruction word from an internal word-addressed instruction ROM, and registers it into the IF/ID pipeline register for decode. Provides stall/flush control for hazard and branch/jump handling. Signals fetch faults for misaligned or out-of-range addresses.

Parameters:
DEPTH, 256, instruction ROM size in 32-bit words (power of 2, >=2)
ADDR_BITS, 8, word-index width; must equal log2(DEPTH)
NOP_WORD, 32'h00000000, word inserted on flush, fault or reset

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
address  input  32  current PC from pc stage (byte address)
resetControl  input  1  high while pc is in reset; fetch waits until low
stall  input  1  hold IF/ID register contents (hazard stall)
flush  input  1  squash the instruction being fetched (branch/jump taken)
romWe  input  1  ROM write enable (bench/loader); ignored while fetching
romWaddr  input  ADDR_BITS  ROM write word index
romWdata  input  32  ROM write data
instruction  output  32  IF/ID registered instruction
pcOut  output  32  IF/ID registered address of `instruction`
pcPlus4  output  32  IF/ID registered pcOut+4
valid  output  1  IF/ID contents are a real instruction
fetchFault  output  1  registered; instruction slot came from a bad address

Behaviour:
- Reset (`reset`=1 at edge): state=WAIT; instruction=NOP_WORD, pcOut=0, pcPlus4=0, valid=0, fetchFault=0. Reset overrides all other inputs. ROM contents are not cleared.
- FSM states: WAIT, FETCH, HOLD.
  - WAIT: outputs stay at reset values. Moves to FETCH at the first edge where resetControl=0. While resetControl=1, remains in WAIT. romWe writes are accepted only in WAIT.
  - FETCH: every edge captures {ROM[address[ADDR_BITS+1:2]], address, address+4} and sets valid=1. Latency is 1 cycle: address present before edge N appears on the outputs after edge N.
  - HOLD: entered from FETCH when stall=1 at an edge. All IF/ID outputs hold. Returns to FETCH at the edge where stall=0, and captures the current address on that same edge.
  - resetControl=1 in FETCH or HOLD: the next edge goes to WAIT and clears the outputs as on reset.
- Priority at an edge: reset > resetControl > flush > stall > normal fetch.
- flush=1 (FETCH or HOLD): instruction=NOP_WORD, valid=0, fetchFault=0. pcOut/pcPlus4 still capture address and address+4. State goes to FETCH even if stall=1 on the same edge.
- Fault: the address is misaligned (address[1:0]!=0) or out of range (address[31:ADDR_BITS+2]!=0). The fetched slot gets instruction=NOP_WORD, valid=0, fetchFault=1, with pcOut=address. Fetching continues on the next edge; the stage does not halt.
- pcPlus4: 32-bit modulo add. 32'hFFFFFFFC gives 32'h00000000 with no flag.
- ROM read is combinational from `address` and is registered only in IF/ID. There is no other internal pipeline.
- romWe in FETCH/HOLD is ignored.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: adds outputs fetchCount[31:0] and stallCount[31:0], both cleared by reset.
  - fetchCount increments on each edge in FETCH that loads valid=1.
  - stallCount increments on each edge spent entering or remaining in HOLD.
  - Both wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Load ROM[0]=0x20080005 and ROM[1]=0x2009000A in WAIT. Pulse reset, then drop resetControl, with address=0x0 then 0x4. Required: instruction=0x20080005, pcOut=0x0, pcPlus4=0x4, valid=1 one cycle after the first FETCH edge. Next cycle: 0x2009000A, pcOut=0x4.
2. During fetch of address 0x8, assert stall for 3 cycles while address changes. Required: outputs frozen at pcOut=0x8. At the edge where stall=0, the current address is captured (stallCount=3 with FETCH_PERF_EN).
3. Assert flush and stall together at address 0xC. Required: instruction=0x00000000, valid=0, pcOut=0xC, and state FETCH on the next cycle.
4. Set address=0x6, then address=0x400 (DEPTH=256). Required: valid=0, fetchFault=1, instruction=NOP, pcOut=0x6 / 0x400. Then address=0x10 fetches normally with fetchFault=0.
5. Assert reset mid-fetch, then raise resetControl for 2 cycles. Required: all outputs are 0/NOP and valid=0 while in WAIT. Fetch resumes one edge after resetControl falls. ROM contents are preserved.
6. Set address=0xFFFFFFFC. Required: pcPlus4=0x00000000 and fetchFault=1 (out of range).
